// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and stall controller for the 5-stage pipeline.
// Adds multi-cycle bubbles, holds on dmem wait, flushes on branch, counts bubble cycles.
module hazard_stall_ctrl #(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_reg_rt,
  input  logic [REG_ADDR_W-1:0] if_id_reg_rs,
  input  logic [REG_ADDR_W-1:0] if_id_reg_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  branch_taken,
  input  logic                  dmem_stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  mux_select_stall,
  output logic                  if_id_flush,
  output logic                  pipe_hold,
  output logic [CNT_W-1:0]      stall_cycles
);

  typedef enum logic {
    S_IDLE,
    S_STALL
  } state_t;

  localparam logic [3:0]       REM_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_rem;
  logic [3:0]       w_rem_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hz;
  logic             w_cnt_inc;

  // Register zero is hard-wired, so a load targeting it never conflicts.
  assign w_hz = id_ex_mem_read && (id_ex_reg_rt != '0) &&
                ((id_ex_reg_rt == if_id_reg_rs) ||
                 (if_id_uses_rt && (id_ex_reg_rt == if_id_reg_rt)));

  // Prioritised output decode and next-state selection.
  always_comb begin
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    mux_select_stall = 1'b0;
    if_id_flush      = 1'b0;
    pipe_hold        = 1'b0;
    w_state_nxt      = r_state;
    w_rem_nxt        = r_rem;
    if (!rst_n) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      mux_select_stall = 1'b1;
      w_state_nxt      = S_IDLE;
      w_rem_nxt        = 4'd0;
    end else if (dmem_stall) begin
      pipe_hold   = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (branch_taken) begin
      if_id_flush      = 1'b1;
      mux_select_stall = 1'b1;
      w_state_nxt      = S_IDLE;
      w_rem_nxt        = 4'd0;
    end else if (r_state == S_STALL) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      mux_select_stall = 1'b1;
      if (r_rem > 4'd1) begin
        w_rem_nxt = r_rem - 4'd1;
      end else begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = 4'd0;
      end
    end else if (w_hz) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      mux_select_stall = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        w_state_nxt = S_STALL;
        w_rem_nxt   = REM_INIT;
      end
    end
  end

  assign w_cnt_inc = mux_select_stall && !branch_taken && (r_cnt != CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= 4'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: three parameterisations share one stimulus stream and are
// checked against an "owed bubbles" reference model.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mr = 1'b0;
  logic [4:0] lrt = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic       uses = 1'b0;
  logic       br = 1'b0;
  logic       dm = 1'b0;

  logic [2:0]  pc_w, ifid_w, mux_w, fl_w, hold_w;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) u_lsc1 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_reg_rt(lrt),
    .if_id_reg_rs(rs), .if_id_reg_rt(rt), .if_id_uses_rt(uses),
    .branch_taken(br), .dmem_stall(dm), .pc_write(pc_w[0]), .if_id_write(ifid_w[0]),
    .mux_select_stall(mux_w[0]), .if_id_flush(fl_w[0]), .pipe_hold(hold_w[0]),
    .stall_cycles(cnt0));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) u_lsc3 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_reg_rt(lrt),
    .if_id_reg_rs(rs), .if_id_reg_rt(rt), .if_id_uses_rt(uses),
    .branch_taken(br), .dmem_stall(dm), .pc_write(pc_w[1]), .if_id_write(ifid_w[1]),
    .mux_select_stall(mux_w[1]), .if_id_flush(fl_w[1]), .pipe_hold(hold_w[1]),
    .stall_cycles(cnt1));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(4), .CNT_W(2)) u_lsc4 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_reg_rt(lrt),
    .if_id_reg_rs(rs), .if_id_reg_rt(rt), .if_id_uses_rt(uses),
    .branch_taken(br), .dmem_stall(dm), .pc_write(pc_w[2]), .if_id_write(ifid_w[2]),
    .mux_select_stall(mux_w[2]), .if_id_flush(fl_w[2]), .pipe_hold(hold_w[2]),
    .stall_cycles(cnt2));

  typedef struct {
    int       inst;
    logic     pc, ifid, mux, fl, hold;
    int       cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: bubbles still owed and bubble-cycle tally.
  int lsc  [3] = '{1, 3, 4};
  int cmax [3] = '{65535, 65535, 3};
  int owed [3] = '{0, 0, 0};
  int tally[3] = '{0, 0, 0};

  task automatic step(input logic i_rst, input logic i_mr, input logic [4:0] i_lrt,
                      input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_uses,
                      input logic i_br, input logic i_dm);
    bit   hazard;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = i_rst; mr = i_mr; lrt = i_lrt; rs = i_rs; rt = i_rt;
    uses = i_uses; br = i_br; dm = i_dm;
    hazard = i_mr && (i_lrt != 0) && ((i_lrt == i_rs) || (i_uses && i_lrt == i_rt));
    for (int k = 0; k < 3; k++) begin
      e.inst = k;
      e.pc = 1'b1; e.ifid = 1'b1; e.mux = 1'b0; e.fl = 1'b0; e.hold = 1'b0;
      if (!i_rst) begin
        owed[k] = 0; tally[k] = 0;
        e.pc = 1'b0; e.ifid = 1'b0; e.mux = 1'b1;
        e.cnt = 0;
      end else begin
        e.cnt = tally[k];
        if (i_dm) begin
          e.hold = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
        end else if (i_br) begin
          e.fl = 1'b1; e.mux = 1'b1;
          owed[k] = 0;
        end else if (owed[k] > 0 || hazard) begin
          e.pc = 1'b0; e.ifid = 1'b0; e.mux = 1'b1;
          owed[k] = (owed[k] > 0) ? owed[k] - 1 : lsc[k] - 1;
          if (tally[k] < cmax[k]) tally[k]++;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic void chk(input int k, input string name, input int got, input int want);
    if (got != want) begin
      n_err++;
      $display("FAIL inst%0d %s: got %0d expected %0d at %0t", k, name, got, want, $time);
    end
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        int   c;
        e = exp_q.pop_front();
        c = (e.inst == 0) ? int'(cnt0) : (e.inst == 1) ? int'(cnt1) : int'(cnt2);
        n_vec++;
        chk(e.inst, "pc_write", int'(pc_w[e.inst]), int'(e.pc));
        chk(e.inst, "if_id_write", int'(ifid_w[e.inst]), int'(e.ifid));
        chk(e.inst, "mux_select_stall", int'(mux_w[e.inst]), int'(e.mux));
        chk(e.inst, "if_id_flush", int'(fl_w[e.inst]), int'(e.fl));
        chk(e.inst, "pipe_hold", int'(hold_w[e.inst]), int'(e.hold));
        chk(e.inst, "stall_cycles", c, e.cnt);
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // rs match, one load
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // rt match with uses_rt, load drops afterwards
    step(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    idle(2);
    // register zero
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // dmem hold during second bubble
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(5);
    // dmem on the detection cycle, hazard held
    step(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // branch during second bubble
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // branch coincident with hazard in idle
    step(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // reset mid-stall
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // back-to-back hazards for saturation
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(5);
    // random traffic on a small register space to provoke collisions
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised, stateful hazard detection and stall controller for the 5-stage pipeline. It sits beside the IF/ID and ID/EX registers and detects load-use hazards on a configurable register-address width. It holds the resulting stall for a configurable number of bubble cycles, freezes the whole pipeline on data-memory wait, flushes IF/ID on a taken branch, and keeps a saturating stall-cycle counter for performance inspection.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_reg_rt  in  REG_ADDR_W  load destination register.
- if_id_reg_rs  in  REG_ADDR_W  source rs of the instruction in ID.
- if_id_reg_rt  in  REG_ADDR_W  source rt of the instruction in ID.
- if_id_uses_rt  in  1  instruction in ID reads rt as a source.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- dmem_stall  in  1  data memory not ready; the whole pipeline must hold.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register load enable.
- mux_select_stall  out  1  zero the ID/EX control fields (bubble).
- if_id_flush  out  1  clear IF/ID to a NOP.
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cycles  out  CNT_W  saturating count of bubble cycles.

## Operation
- Hazard condition `hz`: id_ex_mem_read AND id_ex_reg_rt != 0 AND (id_ex_reg_rt == if_id_reg_rs OR (if_id_uses_rt AND id_ex_reg_rt == if_id_reg_rt)).
  - Register 0 never creates a hazard.
- States:
  - IDLE.
  - STALL, with a remaining-bubble counter `rem`, 4 bits.
- Output priority, highest first:
  1. dmem_stall: pipe_hold=1, pc_write=0, if_id_write=0, mux_select_stall=0, if_id_flush=0. The state and `rem` freeze.
  2. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, mux_select_stall=1. Next state is IDLE and `rem` is cleared. This aborts any stall in progress.
  3. In STALL: pc_write=0, if_id_write=0, mux_select_stall=1, regardless of `hz`.
  4. In IDLE with hz=1: pc_write=0, if_id_write=0, mux_select_stall=1. If LOAD_STALL_CYCLES>1, next state is STALL with rem=LOAD_STALL_CYCLES-1.
  5. Otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- STALL transitions, each on a non-frozen cycle:
  - rem>1: rem decrements.
  - rem==1: return to IDLE.
- stall_cycles:
  - Increments by 1 on every rising edge where mux_select_stall=1 and branch_taken=0.
  - Saturates at 2^CNT_W-1; it never wraps.

## Timing
- Outputs are combinational from state and inputs; hazard detection has zero-cycle latency.
- A load-use hazard yields exactly LOAD_STALL_CYCLES consecutive bubble cycles, not counting dmem_stall cycles. The detection cycle is the first bubble.
- While rst_n is low (asynchronous):
  - State is IDLE, rem=0, stall_cycles=0.
  - Outputs are forced: pc_write=0, if_id_write=0, mux_select_stall=1, if_id_flush=0, pipe_hold=0.
- On rst_n deassertion the block resumes normal IDLE behaviour in the same cycle.
- Reset asserted mid-STALL abandons the stall; no residual bubble appears after release.
- dmem_stall asserted on a detection cycle: the hold wins and no STALL entry occurs. The hazard is re-evaluated in the next cycle because the inputs are unchanged.
- branch_taken together with hz in IDLE: the flush wins and no stall is entered.

## Test plan
- LOAD_STALL_CYCLES=1, load rt=5 in EX, ID rs=5: exactly one cycle of pc_write=0, if_id_write=0, mux_select_stall=1. Then back to pc_write=1; stall_cycles=1.
- LOAD_STALL_CYCLES=3, load rt=7, ID rt=7, if_id_uses_rt=1:
  - Three consecutive bubble cycles even though id_ex_mem_read drops after the first.
  - stall_cycles=3.
  - The same stimulus with if_id_uses_rt=0 gives no stall.
- Load rt=0 matching ID rs=0: no stall, stall_cycles unchanged.
- LOAD_STALL_CYCLES=3, dmem_stall=1 for 2 cycles during the second bubble:
  - pipe_hold=1 and mux_select_stall=0 for those 2 cycles.
  - Total bubbles still 3; stall_cycles=3.
- LOAD_STALL_CYCLES=4, branch_taken=1 during the second bubble: if_id_flush=1 that cycle, then IDLE with pc_write=1 on the next cycle. Separately, rst_n pulsed low mid-STALL: outputs take their reset values immediately and stall_cycles=0.
- CNT_W=2, five back-to-back single-bubble hazards: stall_cycles reaches 3 and holds at 3.
